// File: rtl/nibble_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : nibble_word_packer
// Description : Packs a stream of P1-bit nibbles into P2-bit words, LSB lane
//               first, with valid/ready handshakes on both sides. A nibble
//               flagged with in_last closes its word early; the unfilled lanes
//               are zero with their keep bits clear. A single pending-word
//               register lets one further word complete while the output word
//               is stalled.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_data/in_valid/
//               in_last/in_ready    - nibble input handshake
//               out_data/out_keep/
//               out_last/out_valid/
//               out_ready           - packed word output handshake
//               word_cnt            - output handshakes, modulo 256
// Revision    : 1.0 - initial release
// ============================================================================
module nibble_word_packer #(
    parameter int  P1 = 4,
    parameter int  P2 = P1 * 2,
    localparam int N  = P2 / P1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [P1-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [P2-1:0] out_data,
    output logic [N-1:0]  out_keep,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [7:0]    word_cnt
);

    localparam int                 c_IDX_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(N - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    localparam logic [0:0] c_FILL  = 1'b0;
    localparam logic [0:0] c_STALL = 1'b1;

    logic [0:0]         r_state;
    logic               r_in_ready;
    logic [c_IDX_W-1:0] r_idx;
    logic [P2-1:0]      r_acc;
    logic [N-1:0]       r_acc_keep;
    logic [P2-1:0]      r_pend_data;
    logic [N-1:0]       r_pend_keep;
    logic               r_pend_last;
    logic [P2-1:0]      r_out_data;
    logic [N-1:0]       r_out_keep;
    logic               r_out_last;
    logic               r_out_valid;
    logic [7:0]         r_word_cnt;

    logic               w_accept;
    logic               w_drain;
    logic               w_complete;
    logic [P2-1:0]      w_word;
    logic [N-1:0]       w_word_keep;

    assign w_accept   = in_valid & r_in_ready;
    assign w_drain    = r_out_valid & out_ready;
    assign w_complete = w_accept & ((r_idx == c_LAST_IDX) | in_last);

    // Accumulator with the incoming nibble merged into the current lane.
    // Lanes above idx are still zero, which gives the zero padding for free.
    always_comb begin
        w_word      = r_acc;
        w_word_keep = r_acc_keep;
        for (int i = 0; i < N; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_word[i*P1 +: P1] = in_data;
                w_word_keep[i]     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_FILL;
            r_in_ready  <= 1'b1;
            r_idx       <= '0;
            r_acc       <= '0;
            r_acc_keep  <= '0;
            r_pend_data <= '0;
            r_pend_keep <= '0;
            r_pend_last <= 1'b0;
            r_out_data  <= '0;
            r_out_keep  <= '0;
            r_out_last  <= 1'b0;
            r_out_valid <= 1'b0;
            r_word_cnt  <= 8'd0;
        end else begin
            if (w_drain) begin
                r_word_cnt <= r_word_cnt + 8'd1;
            end

            if (w_accept) begin
                if (w_complete) begin
                    r_idx      <= '0;
                    r_acc      <= '0;
                    r_acc_keep <= '0;
                end else begin
                    r_idx      <= r_idx + c_IDX_ONE;
                    r_acc      <= w_word;
                    r_acc_keep <= w_word_keep;
                end
            end

            case (r_state)
                c_FILL: begin
                    // Accepts only happen in FILL, so completion is only seen here.
                    if (w_complete) begin
                        if (!r_out_valid || w_drain) begin
                            r_out_data  <= w_word;
                            r_out_keep  <= w_word_keep;
                            r_out_last  <= in_last;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_pend_data <= w_word;
                            r_pend_keep <= w_word_keep;
                            r_pend_last <= in_last;
                            r_state     <= c_STALL;
                            r_in_ready  <= 1'b0;
                        end
                    end else if (w_drain) begin
                        // out_data deliberately keeps its last value.
                        r_out_valid <= 1'b0;
                    end
                end
                c_STALL: begin
                    if (w_drain) begin
                        r_out_data  <= r_pend_data;
                        r_out_keep  <= r_pend_keep;
                        r_out_last  <= r_pend_last;
                        r_out_valid <= 1'b1;
                        r_state     <= c_FILL;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= c_FILL;
                    r_in_ready <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_out_data;
    assign out_keep  = r_out_keep;
    assign out_last  = r_out_last;
    assign out_valid = r_out_valid;
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_nibble_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_word_packer
// Description : Self-checking bench for nibble_word_packer (P1=4, P2=8, N=2).
//               Expected words go into a queue when stimulus is issued; a
//               monitor pops and compares on every output handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_word_packer;

    localparam int c_P1 = 4;
    localparam int c_P2 = 8;
    localparam int c_N  = 2;

    typedef struct packed {
        logic [c_P2-1:0] data;
        logic [c_N-1:0]  keep;
        logic            last;
    } word_t;

    logic            clk;
    logic            rst;
    logic [c_P1-1:0] in_data;
    logic            in_valid;
    logic            in_last;
    logic            in_ready;
    logic [c_P2-1:0] out_data;
    logic [c_N-1:0]  out_keep;
    logic            out_last;
    logic            out_valid;
    logic            out_ready;
    logic [7:0]      word_cnt;

    word_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    nibble_word_packer #(.P1(c_P1), .P2(c_P2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [1:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    // Presents one nibble just after a rising edge and holds it until accepted.
    task automatic send(input logic [3:0] d, input logic l);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_word_cnt",  {24'd0, word_cnt},  32'd0);
        rst = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            word_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word: got data=%h keep=%b last=%b, required no word",
                         out_data, out_keep, out_last);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e.data || out_keep !== e.keep || out_last !== e.last) begin
                    errors++;
                    $display("FAIL word: got data=%h keep=%b last=%b, required data=%h keep=%b last=%b",
                             out_data, out_keep, out_last, e.data, e.keep, e.last);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        logic [7:0] b;
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'd0, in_ready},  32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_data",  {24'd0, out_data},  32'd0);
        check("reset_out_keep",  {30'd0, out_keep},  32'd0);
        check("reset_out_last",  {31'd0, out_last},  32'd0);
        check("reset_word_cnt",  {24'd0, word_cnt},  32'd0);
        rst = 1'b0;

        // 1: two full nibbles.
        out_ready = 1'b1;
        push(8'hA3, 2'b11, 1'b0);
        send(4'h3, 1'b0);
        send(4'hA, 1'b0);
        check("t1_latency_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        check("t1_word_cnt",   {24'd0, word_cnt},  32'd1);
        check("t1_valid_drop", {31'd0, out_valid}, 32'd0);
        check("t1_data_kept",  {24'd0, out_data},  32'hA3);

        // Idle inputs with in_last high must be ignored.
        in_data = 4'hF;
        in_last = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_last = 1'b0;
        check("idle_no_word", {31'd0, out_valid}, 32'd0);

        // 2: early close after one nibble.
        push(8'h05, 2'b01, 1'b1);
        send(4'h5, 1'b1);
        @(posedge clk);
        #1;
        check("t2_word_cnt", {24'd0, word_cnt}, 32'd2);

        // 3: stalled output with a pending word.
        out_ready = 1'b0;
        push(8'h21, 2'b11, 1'b0);
        push(8'h43, 2'b11, 1'b0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        send(4'h3, 1'b0);
        send(4'h4, 1'b0);
        check("t3_in_ready_low", {31'd0, in_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t3_held_data",  {24'd0, out_data},  32'h21);
        check("t3_held_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t3_b2b_valid", {31'd0, out_valid}, 32'd1);
        check("t3_b2b_data",  {24'd0, out_data},  32'h43);
        check("t3_in_ready",  {31'd0, in_ready},  32'd1);
        @(posedge clk);
        #1;
        check("t3_valid_drop", {31'd0, out_valid}, 32'd0);
        check("t3_word_cnt",   {24'd0, word_cnt},  32'd4);

        // 5: reset discards a partial word.
        send(4'h7, 1'b0);
        do_reset();
        push(8'h21, 2'b11, 1'b0);
        send(4'h1, 1'b0);
        send(4'h2, 1'b0);
        @(posedge clk);
        #1;
        check("t5_word_cnt", {24'd0, word_cnt}, 32'd1);

        // 4: word counter wrap.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            push(b, 2'b11, 1'b0);
            send(b[3:0], 1'b0);
            send(b[7:4], 1'b0);
        end
        @(posedge clk);
        #1;
        check("t4_wrap_0", {24'd0, word_cnt}, 32'd0);
        push(8'h5A, 2'b11, 1'b0);
        send(4'hA, 1'b0);
        send(4'h5, 1'b0);
        @(posedge clk);
        #1;
        check("t4_wrap_1", {24'd0, word_cnt}, 32'd1);

        // 6: continuous streaming, one nibble per cycle.
        for (int j = 0; j < 50; j++) begin
            b = {4'((2 * j + 1) % 16), 4'((2 * j) % 16)};
            push(b, 2'b11, 1'b0);
        end
        low = 0;
        for (int k = 0; k < 100; k++) begin
            in_data  = 4'(k % 16);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready !== 1'b1) low++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_ready_low_cycles", low, 32'd0);
        check("t6_word_cnt", {24'd0, word_cnt}, 32'd51);

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
